mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
Memory-access stage plus MEM/WB pipeline register of the 5-stage 64-bit RISC pipeline. Sits directly downstream of the EX/MEM register.
- Consumes its ALU result, store data, destination register and control bits.
- Runs a ready-handshaked data-memory access for loads and stores.
- Stalls upstream while the access is outstanding.
- Presents registered write-back data to the register file and forwarding unit.

Parameters:
XLEN, 64, datapath/address width
REGW, 5, register index width
TIMEOUT, 255, max ACCESS cycles before abort; 0 disables watchdog

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
aluout  in  XLEN  ALU result / memory address from EX/MEM
readdata2  in  XLEN  store data from EX/MEM
writeregister  in  REGW  destination register from EX/MEM
memread  in  1  load
memwrite  in  1  store
memtoreg  in  1  write-back selects memory data
regwrite  in  1  register write enable
dmem_req  out  1  memory request
dmem_we  out  1  1=store, 0=load
dmem_addr  out  XLEN  memory address
dmem_wdata  out  XLEN  store data
dmem_ready  in  1  access complete this cycle
dmem_rdata  in  XLEN  load data, valid when dmem_ready=1
stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
wb_data  out  XLEN  registered write-back data
wb_reg  out  REGW  registered destination
wb_regwrite  out  1  registered write enable
timeout_err  out  1  sticky watchdog abort flag

Behaviour:
Reset (async, any state): FSM=IDLE.
- Outputs dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_data, wb_reg, wb_regwrite, timeout_err are all 0.
- Latched request registers and the watchdog counter clear.
- An access in flight is dropped; the memory side must tolerate req falling without ready.

Upstream contract: while stall=1, all EX/MEM inputs are held stable.

State IDLE:
- If memread|memwrite = 0: stall=0. At the edge, MEM/WB loads:
  - wb_data=aluout
  - wb_reg=writeregister
  - wb_regwrite=regwrite & (writeregister!=0)
  - Latency 1 cycle.
- If memread|memwrite = 1: stall=1 (combinational from inputs). At the edge:
  - Latch aluout, readdata2, memwrite, memtoreg, regwrite, writeregister.
  - Go to ACCESS.
  - MEM/WB loads a bubble (wb_regwrite=0; wb_data and wb_reg keep their values).

State ACCESS:
- Memory outputs: dmem_req=1, dmem_we=latched memwrite, dmem_addr=latched aluout, dmem_wdata=latched readdata2. All come from registers, stable for the whole access.
- stall = !dmem_ready (combinational path from dmem_ready, permitted).
- dmem_ready=1 at an edge:
  - MEM/WB loads wb_data = latched memtoreg ? dmem_rdata : latched aluout.
  - wb_reg=latched reg; wb_regwrite=latched regwrite & (reg!=0).
  - FSM→IDLE; counter clears.
  - Upstream advances on the same edge, so the next instruction is seen in IDLE the following cycle.
- dmem_ready=0: counter increments. Each stall cycle loads a bubble into MEM/WB.
- Watchdog: when TIMEOUT!=0 and the counter reaches TIMEOUT-1 with dmem_ready=0:
  - stall=0 that cycle.
  - Next edge: FSM→IDLE, timeout_err←1 (cleared only by reset), MEM/WB loads wb_regwrite=0.
- ready and timeout in the same cycle: ready wins, no error.

Back-to-back memory ops: minimum 2 cycles each (IDLE + ACCESS), one bubble between write-backs.

Widths and data:
- Address and data are passed unmodified; no alignment check or sub-word handling.
- Counter width is $clog2(TIMEOUT+1), minimum 1.
- dmem_ready is ignored in IDLE.

Decomposition:
Shared package (pipeline_pkg):
- XLEN, REGW
- mem_state_t enum {IDLE, ACCESS}
- mem_wb_t struct {data, reg, regwrite}

Sub-module mem_wb_reg: the async-reset MEM/WB register with load and bubble controls, reused by the forwarding unit bench. The FSM, request latch and watchdog stay in mem_wb_stage.

Test Plan:
- ALU op: aluout=0x1234, writeregister=5, regwrite=1, no memread/memwrite → stall=0; next cycle wb_data=0x1234, wb_reg=5, wb_regwrite=1.
- Load with delay: memread=1, memtoreg=1, aluout=0x100, reg=7; dmem_ready high on the 3rd ACCESS cycle with rdata=0xDEADBEEFCAFEF00D.
  - stall=1 for 3 cycles; dmem_addr=0x100, dmem_we=0.
  - Then wb_data=0xDEADBEEFCAFEF00D, wb_reg=7, wb_regwrite=1.
- Store: memwrite=1, aluout=0x40, readdata2=0xAA, ready immediate → dmem_we=1, dmem_wdata=0xAA for one ACCESS cycle; stall=1 for 1 cycle; wb_regwrite=0.
- Timeout: TIMEOUT=4, load, ready never asserted → 4 ACCESS cycles; stall drops in the 4th; timeout_err=1 after, stays 1; wb_regwrite=0; FSM back in IDLE.
- Reset mid-access: rst_n low during ACCESS → dmem_req, stall and all wb_* go to 0 immediately; after release, an ALU op completes normally.
- x0 write: regwrite=1, writeregister=0, aluout=0x55 → wb_regwrite=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and widths for the 5-stage 64-bit RISC pipeline.
// Imported by every stage so datapath widths stay consistent across the slice.
package pipeline_pkg;

  localparam int XLEN = 64;
  localparam int REGW = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  // One MEM/WB register entry; "rd" because "reg" is a reserved word
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [REGW-1:0] rd;
    logic            regwrite;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with async reset, load and bubble controls.
// A bubble kills only the write enable so forwarding still sees the last data/rd.
module mem_wb_reg
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            bubble,
  input  logic [XLEN-1:0] d_data,
  input  logic [REGW-1:0] d_rd,
  input  logic            d_regwrite,
  output logic [XLEN-1:0] q_data,
  output logic [REGW-1:0] q_rd,
  output logic            q_regwrite
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_data     <= '0;
      q_rd       <= '0;
      q_regwrite <= 1'b0;
    end else if (load) begin
      q_data     <= d_data;
      q_rd       <= d_rd;
      q_regwrite <= d_regwrite;
    end else if (bubble) begin
      q_regwrite <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB register: runs one ready-handshaked data-memory
// access per load/store, stalls upstream meanwhile, and aborts hung accesses via a watchdog.
module mem_wb_stage
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] aluout,
  input  logic [XLEN-1:0] readdata2,
  input  logic [REGW-1:0] writeregister,
  input  logic            memread,
  input  logic            memwrite,
  input  logic            memtoreg,
  input  logic            regwrite,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall,
  output logic [XLEN-1:0] wb_data,
  output logic [REGW-1:0] wb_reg,
  output logic            wb_regwrite,
  output logic            timeout_err
);

  localparam int            CW       = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit            WD_EN    = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  mem_state_t      state, state_next;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] req_addr, req_wdata;
  logic [REGW-1:0] req_rd;
  logic            req_we, req_memtoreg, req_regwrite;
  logic            mem_op, wd_fire, stall_raw, wb_load, wb_bubble;
  mem_wb_t         wb_next;

  assign mem_op = memread | memwrite;

  always_comb begin
    state_next = state;
    stall_raw  = 1'b0;
    wd_fire    = 1'b0;
    wb_load    = 1'b0;
    wb_bubble  = 1'b0;
    wb_next    = '0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stall_raw  = 1'b1;
          wb_bubble  = 1'b1;
          state_next = ACCESS;
        end else begin
          wb_load          = 1'b1;
          wb_next.data     = aluout;
          wb_next.rd       = writeregister;
          wb_next.regwrite = regwrite && (writeregister != '0);
        end
      end
      ACCESS: begin
        // Ready takes priority over the watchdog firing in the same cycle
        if (dmem_ready) begin
          wb_load          = 1'b1;
          wb_next.data     = req_memtoreg ? dmem_rdata : req_addr;
          wb_next.rd       = req_rd;
          wb_next.regwrite = req_regwrite && (req_rd != '0);
          state_next       = IDLE;
        end else begin
          wb_bubble = 1'b1;
          if (WD_EN && (cnt == CNT_LAST)) begin
            wd_fire    = 1'b1;
            state_next = IDLE;
          end else begin
            stall_raw = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Nothing upstream should be frozen while the stage is held in reset
  assign stall = rst_n & stall_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      timeout_err  <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_rd       <= '0;
      req_we       <= 1'b0;
      req_memtoreg <= 1'b0;
      req_regwrite <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && mem_op) begin
        req_addr     <= aluout;
        req_wdata    <= readdata2;
        req_rd       <= writeregister;
        req_we       <= memwrite;
        req_memtoreg <= memtoreg;
        req_regwrite <= regwrite;
      end
      if (state == ACCESS && !dmem_ready && !wd_fire) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      if (wd_fire) begin
        timeout_err <= 1'b1;
      end
    end
  end

  assign dmem_req   = (state == ACCESS);
  assign dmem_we    = dmem_req & req_we;
  assign dmem_addr  = req_addr;
  assign dmem_wdata = req_wdata;

  mem_wb_reg u_mem_wb_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (wb_load),
    .bubble     (wb_bubble),
    .d_data     (wb_next.data),
    .d_rd       (wb_next.rd),
    .d_regwrite (wb_next.regwrite),
    .q_data     (wb_data),
    .q_rd       (wb_reg),
    .q_regwrite (wb_regwrite)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (watchdog shortened to 4 cycles): ALU op, x0 write,
// delayed load, store, watchdog abort and reset mid-access, with hand-computed values.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic [63:0] aluout, readdata2, dmem_rdata;
  logic [4:0]  writeregister;
  logic        memread, memwrite, memtoreg, regwrite, dmem_ready;
  logic        dmem_req, dmem_we, stall, wb_regwrite, timeout_err;
  logic [63:0] dmem_addr, dmem_wdata, wb_data;
  logic [4:0]  wb_reg;

  int compared   = 0;
  int mismatched = 0;

  mem_wb_stage #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .aluout        (aluout),
    .readdata2     (readdata2),
    .writeregister (writeregister),
    .memread       (memread),
    .memwrite      (memwrite),
    .memtoreg      (memtoreg),
    .regwrite      (regwrite),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ready    (dmem_ready),
    .dmem_rdata    (dmem_rdata),
    .stall         (stall),
    .wb_data       (wb_data),
    .wb_reg        (wb_reg),
    .wb_regwrite   (wb_regwrite),
    .timeout_err   (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL sim_time_limit: observed no finish, expected finish");
    $fatal(1, "[TB] time limit");
  end

  task automatic applyStimulus(input logic [63:0] alu, input logic [63:0] rd2,
                               input logic [4:0] wr, input logic mr, input logic mw,
                               input logic m2r, input logic rw);
    aluout        = alu;
    readdata2     = rd2;
    writeregister = wr;
    memread       = mr;
    memwrite      = mw;
    memtoreg      = m2r;
    regwrite      = rw;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    applyStimulus(64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("rst_wb_data", wb_data, 64'h0);
    checkOutput("rst_wb_reg", {59'd0, wb_reg}, 64'h0);
    checkOutput("rst_wb_regwrite", {63'd0, wb_regwrite}, 64'h0);
    checkOutput("rst_dmem_req", {63'd0, dmem_req}, 64'h0);
    checkOutput("rst_timeout_err", {63'd0, timeout_err}, 64'h0);
    checkOutput("rst_stall", {63'd0, stall}, 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ALU op, one-cycle latency
    applyStimulus(64'h1234, 64'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("alu_stall", {63'd0, stall}, 64'h0);
    step();
    checkOutput("alu_wb_data", wb_data, 64'h1234);
    checkOutput("alu_wb_reg", {59'd0, wb_reg}, 64'd5);
    checkOutput("alu_wb_regwrite", {63'd0, wb_regwrite}, 64'h1);

    // Write to x0 is suppressed
    applyStimulus(64'h55, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("x0_wb_regwrite", {63'd0, wb_regwrite}, 64'h0);
    checkOutput("x0_wb_data", wb_data, 64'h55);

    // Load, ready on the third ACCESS cycle
    applyStimulus(64'h100, 64'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("ld_idle_stall", {63'd0, stall}, 64'h1);
    step();
    checkOutput("ld_a1_req", {63'd0, dmem_req}, 64'h1);
    checkOutput("ld_a1_addr", dmem_addr, 64'h100);
    checkOutput("ld_a1_we", {63'd0, dmem_we}, 64'h0);
    checkOutput("ld_a1_stall", {63'd0, stall}, 64'h1);
    checkOutput("ld_a1_bubble", {63'd0, wb_regwrite}, 64'h0);
    checkOutput("ld_a1_hold_data", wb_data, 64'h55);
    step();
    checkOutput("ld_a2_stall", {63'd0, stall}, 64'h1);
    checkOutput("ld_a2_addr", dmem_addr, 64'h100);
    dmem_ready = 1'b1;
    dmem_rdata = 64'hDEADBEEFCAFEF00D;
    #1;
    checkOutput("ld_a3_stall", {63'd0, stall}, 64'h0);
    step();
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    checkOutput("ld_wb_data", wb_data, 64'hDEADBEEFCAFEF00D);
    checkOutput("ld_wb_reg", {59'd0, wb_reg}, 64'd7);
    checkOutput("ld_wb_regwrite", {63'd0, wb_regwrite}, 64'h1);
    checkOutput("ld_done_req", {63'd0, dmem_req}, 64'h0);

    // Store with immediate ready
    applyStimulus(64'h40, 64'hAA, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("st_idle_stall", {63'd0, stall}, 64'h1);
    step();
    dmem_ready = 1'b1;
    #1;
    checkOutput("st_we", {63'd0, dmem_we}, 64'h1);
    checkOutput("st_wdata", dmem_wdata, 64'hAA);
    checkOutput("st_addr", dmem_addr, 64'h40);
    checkOutput("st_stall", {63'd0, stall}, 64'h0);
    step();
    dmem_ready = 1'b0;
    checkOutput("st_wb_regwrite", {63'd0, wb_regwrite}, 64'h0);
    checkOutput("st_wb_data", wb_data, 64'h40);
    checkOutput("st_done_req", {63'd0, dmem_req}, 64'h0);

    // Watchdog: ready never comes
    applyStimulus(64'h200, 64'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      step();
      checkOutput($sformatf("to_a%0d_stall", i), {63'd0, stall}, 64'h1);
    end
    step();
    checkOutput("to_a4_stall", {63'd0, stall}, 64'h0);
    checkOutput("to_a4_req", {63'd0, dmem_req}, 64'h1);
    checkOutput("to_a4_err", {63'd0, timeout_err}, 64'h0);
    applyStimulus(64'h77, 64'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("to_err_set", {63'd0, timeout_err}, 64'h1);
    checkOutput("to_idle_req", {63'd0, dmem_req}, 64'h0);
    checkOutput("to_wb_regwrite", {63'd0, wb_regwrite}, 64'h0);
    checkOutput("to_next_stall", {63'd0, stall}, 64'h0);
    step();
    checkOutput("to_next_wb_data", wb_data, 64'h77);
    checkOutput("to_next_wb_regwrite", {63'd0, wb_regwrite}, 64'h1);
    checkOutput("to_err_sticky", {63'd0, timeout_err}, 64'h1);

    // Reset in the middle of an access
    applyStimulus(64'h300, 64'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    checkOutput("rm_req_before", {63'd0, dmem_req}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rm_req", {63'd0, dmem_req}, 64'h0);
    checkOutput("rm_stall", {63'd0, stall}, 64'h0);
    checkOutput("rm_wb_data", wb_data, 64'h0);
    checkOutput("rm_wb_reg", {59'd0, wb_reg}, 64'h0);
    checkOutput("rm_wb_regwrite", {63'd0, wb_regwrite}, 64'h0);
    checkOutput("rm_err_cleared", {63'd0, timeout_err}, 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(64'hABC, 64'h0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rm_alu_stall", {63'd0, stall}, 64'h0);
    step();
    checkOutput("rm_alu_wb_data", wb_data, 64'hABC);
    checkOutput("rm_alu_wb_reg", {59'd0, wb_reg}, 64'd6);
    checkOutput("rm_alu_wb_regwrite", {63'd0, wb_regwrite}, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
